// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter
package dmem_arb_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    typedef enum logic {ST_CLEAR, ST_ARB} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a registered priority bit
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio_q, prio_d;
    assign gnt[SEL_A] = req[SEL_A] & (!req[SEL_B] | prio_q == SEL_A);
    assign gnt[SEL_B] = req[SEL_B] & (!req[SEL_A] | prio_q == SEL_B);
    assign prio_d = gnt[SEL_A] ? SEL_B : gnt[SEL_B] ? SEL_A : prio_q;
    always_ff @(posedge clk) begin
        prio_q <= rst ? SEL_A : prio_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: zero-sweeps the data memory after reset, then round-robins
// its single port between requesters A and B
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              init_busy
);
    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [1:0]        req, gnt;
    logic              clearing, arbitrating;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            cnt_q   <= '0;
        end else if (state_q == ST_CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_q <= ST_ARB;
        end
    end

    // Memory is never enabled while rst is high, so no partial access can occur
    assign clearing    = !rst && state_q == ST_CLEAR;
    assign arbitrating = !rst && state_q == ST_ARB;
    assign req         = {b_req, a_req} & {2{arbitrating}};

    rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req), .gnt(gnt));

    assign a_gnt     = gnt[SEL_A];
    assign b_gnt     = gnt[SEL_B];
    assign init_busy = rst ? CLEAR_ON_RESET : state_q == ST_CLEAR;
    assign mem_ena   = clearing | a_gnt | b_gnt;
    assign mem_wena  = clearing | (a_gnt & a_we) | (b_gnt & b_we);
    assign mem_addr  = a_gnt ? a_addr : b_gnt ? b_addr : clearing ? cnt_q : '0;
    assign mem_wdata = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    assign a_rdata   = a_gnt ? mem_rdata : '0;
    assign b_rdata   = b_gnt ? mem_rdata : '0;
endmodule
